// File: rtl/peripheral_tl_pkg.sv
// Shared TL-UL opcode encodings and arbiter state type for the peripheral arbiter.
package peripheral_tl_pkg;

  typedef enum logic [2:0] {
    TL_PUT_FULL_DATA    = 3'd0,
    TL_PUT_PARTIAL_DATA = 3'd1,
    TL_GET              = 3'd4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    TL_ACCESS_ACK      = 3'd0,
    TL_ACCESS_ACK_DATA = 3'd1
  } tl_d_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

endpackage

// File: rtl/peripheral_rr_arbiter.sv
// Round-robin picker: first asserted request strictly after ptr, wrapping modulo N.
module peripheral_rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    cand = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'(32'(ptr) + k);
      if ((gnt == '0) && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/peripheral_arbiter_tl.sv
// N-to-1 TL-UL channel A arbiter with source-tagged D routing and per-requester
// outstanding-transaction limits.
module peripheral_arbiter_tl
  import peripheral_tl_pkg::*;
#(
  parameter  int unsigned TL_AW     = 32,
  parameter  int unsigned TL_DW     = 32,
  parameter  int unsigned TL_SRCW   = 8,
  parameter  int unsigned TL_SINKW  = 1,
  parameter  int unsigned TL_DBW    = TL_DW >> 3,
  parameter  int unsigned TL_SZW    = $clog2($clog2(TL_DBW) + 1),
  parameter  int unsigned TL_REQ    = 4,
  parameter  int unsigned TL_MAXOUT = 4,
  localparam int unsigned RW        = $clog2(TL_REQ),
  localparam int unsigned LSW       = TL_SRCW - RW
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [TL_REQ*3-1:0]          rq_a_opcode,
  input  logic [TL_REQ*3-1:0]          rq_a_param,
  input  logic [TL_REQ*TL_SZW-1:0]     rq_a_size,
  input  logic [TL_REQ*LSW-1:0]        rq_a_source,
  input  logic [TL_REQ*TL_AW-1:0]      rq_a_address,
  input  logic [TL_REQ*TL_DBW-1:0]     rq_a_mask,
  input  logic [TL_REQ*TL_DW-1:0]      rq_a_data,
  input  logic [TL_REQ-1:0]            rq_a_corrupt,
  input  logic [TL_REQ-1:0]            rq_a_valid,
  output logic [TL_REQ-1:0]            rq_a_ready,

  output logic [TL_REQ*3-1:0]          rq_d_opcode,
  output logic [TL_REQ*3-1:0]          rq_d_param,
  output logic [TL_REQ*TL_SZW-1:0]     rq_d_size,
  output logic [TL_REQ*LSW-1:0]        rq_d_source,
  output logic [TL_REQ*TL_SINKW-1:0]   rq_d_sink,
  output logic [TL_REQ-1:0]            rq_d_denied,
  output logic [TL_REQ*TL_DW-1:0]      rq_d_data,
  output logic [TL_REQ-1:0]            rq_d_corrupt,
  output logic [TL_REQ-1:0]            rq_d_valid,
  input  logic [TL_REQ-1:0]            rq_d_ready,

  output logic [2:0]                   a_opcode,
  output logic [2:0]                   a_param,
  output logic [TL_SZW-1:0]            a_size,
  output logic [TL_SRCW-1:0]           a_source,
  output logic [TL_AW-1:0]             a_address,
  output logic [TL_DBW-1:0]            a_mask,
  output logic [TL_DW-1:0]             a_data,
  output logic                         a_corrupt,
  output logic                         a_valid,
  input  logic                         a_ready,

  input  logic [2:0]                   d_opcode,
  input  logic [2:0]                   d_param,
  input  logic [TL_SZW-1:0]            d_size,
  input  logic [TL_SRCW-1:0]           d_source,
  input  logic [TL_SINKW-1:0]          d_sink,
  input  logic                         d_denied,
  input  logic [TL_DW-1:0]             d_data,
  input  logic                         d_corrupt,
  input  logic                         d_valid,
  output logic                         d_ready
);

  localparam int unsigned OPW = 3;
  localparam int unsigned CW  = $clog2(TL_MAXOUT + 1);

  arb_state_e    state_q, state_d;
  logic [RW-1:0] grant_q, grant_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] outstanding_q [TL_REQ];
  logic [CW-1:0] outstanding_d [TL_REQ];
  logic          err_underflow_q, err_underflow_d;

  logic [TL_REQ-1:0] eligible;
  logic [TL_REQ-1:0] arb_gnt;
  logic [RW-1:0]     arb_idx;
  logic              arb_valid;
  logic              a_fire, d_fire;
  logic [RW-1:0]     d_idx;
  logic [TL_REQ-1:0] inc_vec, dec_vec;

  always_comb begin
    for (int unsigned i = 0; i < TL_REQ; i++) begin
      eligible[i] = rq_a_valid[i] && (outstanding_q[i] < CW'(TL_MAXOUT));
    end
  end

  peripheral_rr_arbiter #(.N(TL_REQ)) u_rr (
    .req (eligible),
    .ptr (rr_ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign arb_valid = |arb_gnt;

  // Downstream A mirrors the held grant; a_valid derives from state so reset kills it at once.
  assign a_valid   = (state_q == ST_HOLD);
  assign a_opcode  = rq_a_opcode [32'(grant_q)*OPW    +: OPW];
  assign a_param   = rq_a_param  [32'(grant_q)*OPW    +: OPW];
  assign a_size    = rq_a_size   [32'(grant_q)*TL_SZW +: TL_SZW];
  assign a_source  = {grant_q, rq_a_source[32'(grant_q)*LSW +: LSW]};
  assign a_address = rq_a_address[32'(grant_q)*TL_AW  +: TL_AW];
  assign a_mask    = rq_a_mask   [32'(grant_q)*TL_DBW +: TL_DBW];
  assign a_data    = rq_a_data   [32'(grant_q)*TL_DW  +: TL_DW];
  assign a_corrupt = rq_a_corrupt[grant_q];
  assign a_fire    = a_valid && a_ready;

  always_comb begin
    rq_a_ready = '0;
    if (state_q == ST_HOLD) rq_a_ready[grant_q] = a_ready;
  end

  // D returns to the requester named by the upper source bits.
  assign d_idx        = d_source[TL_SRCW-1:LSW];
  assign d_ready      = rq_d_ready[d_idx];
  assign d_fire       = d_valid && d_ready;
  assign rq_d_opcode  = {TL_REQ{d_opcode}};
  assign rq_d_param   = {TL_REQ{d_param}};
  assign rq_d_size    = {TL_REQ{d_size}};
  assign rq_d_sink    = {TL_REQ{d_sink}};
  assign rq_d_denied  = {TL_REQ{d_denied}};
  assign rq_d_data    = {TL_REQ{d_data}};
  assign rq_d_corrupt = {TL_REQ{d_corrupt}};

  always_comb begin
    rq_d_valid  = '0;
    rq_d_source = '0;
    rq_d_valid[d_idx] = d_valid;
    rq_d_source[32'(d_idx)*LSW +: LSW] = d_source[LSW-1:0];
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d = arb_idx;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (a_ready) begin
          rr_ptr_d = grant_q;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign inc_vec = a_fire ? (TL_REQ'(1) << grant_q) : '0;
  assign dec_vec = d_fire ? (TL_REQ'(1) << d_idx)   : '0;

  // A simultaneous issue and retire on one requester cancel out; a stray retire holds at zero.
  always_comb begin
    err_underflow_d = err_underflow_q;
    for (int unsigned i = 0; i < TL_REQ; i++) begin
      outstanding_d[i] = outstanding_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        if (outstanding_q[i] < CW'(TL_MAXOUT)) outstanding_d[i] = outstanding_q[i] + CW'(1);
      end else if (dec_vec[i] && !inc_vec[i]) begin
        if (outstanding_q[i] == '0) err_underflow_d = 1'b1;
        else                        outstanding_d[i] = outstanding_q[i] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      grant_q         <= '0;
      rr_ptr_q        <= RW'(TL_REQ - 1);
      err_underflow_q <= 1'b0;
      for (int unsigned i = 0; i < TL_REQ; i++) outstanding_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      rr_ptr_q        <= rr_ptr_d;
      err_underflow_q <= err_underflow_d;
      for (int unsigned i = 0; i < TL_REQ; i++) outstanding_q[i] <= outstanding_d[i];
    end
  end

endmodule

// File: doc/peripheral_arbiter_tl.md
PERIPHERAL_ARBITER_TL -- requirements
Module: peripheral_arbiter_tl

Interface
REQ-001 SHALL have parameter TL_AW, default 32, address width.
REQ-002 SHALL have parameter TL_DW, default 32, data width.
REQ-003 SHALL have parameter TL_SRCW, default 8, manager-side source width.
REQ-004 SHALL have parameter TL_SINKW, default 1, sink width.
REQ-005 SHALL have parameter TL_DBW, default TL_DW>>3, mask width.
REQ-006 SHALL have parameter TL_SZW, default $clog2($clog2(TL_DBW)+1), size width.
REQ-007 SHALL have parameter TL_REQ, default 4, number of requesters (power of two, 2..16).
REQ-008 SHALL have parameter TL_MAXOUT, default 4, maximum outstanding A transactions per requester (1..15).
REQ-009 SHALL derive local parameters RW=$clog2(TL_REQ) and LSW=TL_SRCW-RW, the requester-side source width.
REQ-010 Port clk  input  1  the single clock; all logic on rising edge.
REQ-011 Port reset  input  1  asynchronous, active-low reset.
REQ-012 Ports rq_a_opcode/param/size/source/address/mask/data/corrupt  input  TL_REQ*{3,3,TL_SZW,LSW,TL_AW,TL_DBW,TL_DW,1}  packed per-requester channel A; requester i occupies slice i.
REQ-013 Ports rq_a_valid input, rq_a_ready output  TL_REQ each  per-requester A handshake.
REQ-014 Ports rq_d_opcode/param/size/source/sink/denied/data/corrupt  output  TL_REQ*{3,3,TL_SZW,LSW,TL_SINKW,1,TL_DW,1}  per-requester channel D.
REQ-015 Ports rq_d_valid output, rq_d_ready input  TL_REQ each  per-requester D handshake.
REQ-016 Ports a_opcode/param/size/source/address/mask/data/corrupt/valid output, a_ready input  TL widths  downstream TL-UL channel A.
REQ-017 Ports d_opcode/param/size/source/sink/denied/data/corrupt/valid input, d_ready output  TL widths  downstream TL-UL channel D.

Function
REQ-018 SHALL support single-beat TL-UL only (Get, PutFullData, PutPartialData; responses AccessAck, AccessAckData).
REQ-019 SHALL grant channel A round-robin: search starts at index rr_ptr+1 mod TL_REQ; eligible = rq_a_valid[i] AND outstanding[i] < TL_MAXOUT.
REQ-020 SHALL use a two-state FSM IDLE/HOLD: in IDLE, an eligible requester is registered as grant and FSM enters HOLD the same edge.
REQ-021 In HOLD, SHALL drive a_* from the granted slice combinationally with a_valid=1, and a_source={grant, rq_a_source slice}.
REQ-022 SHALL assert rq_a_ready[grant] = a_ready only in HOLD; all other rq_a_ready = 0.
REQ-023 On a_valid AND a_ready, SHALL set rr_ptr=grant, increment outstanding[grant], and return to IDLE (minimum one idle cycle between grants; throughput 1 per 2 cycles).
REQ-024 SHALL never change grant while a_valid=1 and a_ready=0 (TileLink stability).
REQ-025 SHALL route D combinationally: index j = d_source[TL_SRCW-1:LSW]; rq_d_valid[j]=d_valid, rq_d_source slice j = d_source[LSW-1:0], other D fields broadcast to all slices; d_ready = rq_d_ready[j].
REQ-026 On d_valid AND d_ready, SHALL decrement outstanding[j].
REQ-027 Simultaneous A-fire and D-fire on the same requester SHALL leave outstanding unchanged.
REQ-028 A D response with outstanding[j]=0 SHALL be forwarded, counter held at 0 (no wrap), and sticky internal flag err_underflow set.
REQ-029 outstanding counters SHALL be $clog2(TL_MAXOUT+1) bits and never exceed TL_MAXOUT.

Reset
REQ-030 On reset low: FSM=IDLE, grant=0, rr_ptr=TL_REQ-1 (so requester 0 has first priority), all outstanding=0, err_underflow=0; a_valid=0, all rq_a_ready=0.
REQ-031 Reset asserted mid-HOLD SHALL drop a_valid immediately (asynchronously); in-flight D responses after release are forwarded per REQ-028.

Structure
REQ-032 Opcode constants (Get=4, PutFullData=0, PutPartialData=1, AccessAck=0, AccessAckData=1) and the FSM state enum SHALL live in shared package peripheral_tl_pkg.
REQ-033 Round-robin selection SHALL be a sub-module peripheral_rr_arbiter (inputs req vector, pointer; output one-hot grant and index).

Verification
REQ-034 Requesters 0..3 all valid from reset, a_ready=1 -> downstream grants in order 0,1,2,3,0, a_source upper bits 0,1,2,3.
REQ-035 Requester 2 valid, a_ready low 5 cycles -> a_valid held, a_address stable, grant remains 2; fires on cycle 6, outstanding[2]=1.
REQ-036 Requester 1 issues 4 Gets, no D -> fifth request not granted while requester 3 is still granted.
REQ-037 d_source=8'hC5 with TL_REQ=4 -> rq_d_valid[3]=1, rq_d_source slice 3 = 6'h05; rq_d_ready[3]=0 stalls d_ready.
REQ-038 Same cycle A-fire and D-fire on requester 0 with outstanding=2 -> remains 2.
REQ-039 Reset pulsed while in HOLD -> a_valid=0 within the reset cycle, counters 0, first grant after release is requester 0.
